// File: rtl/io_bus_pkg.sv
// ---------------------------------------------------------------------------
// io_bus_pkg
// Definitions shared by both ends of the internal I/O bus: the request FSM
// state encoding, the default synchronizer depth and the byte-lane pair.
// No ports (package).
// ---------------------------------------------------------------------------
package io_bus_pkg;

   // Default depth of the synchronizers on signals crossing from the far end.
   localparam int SYNC_STAGES_DEF = 2;

   // Request FSM states; the far-end master decodes the same encoding.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_ACT  = 2'd2,
      ST_DONE = 2'd3
   } io_state_e;

   // Byte-lane strobes of one access.
   typedef struct packed {
      logic uds;
      logic lds;
   } io_lanes_t;

endpackage : io_bus_pkg

// File: rtl/io_sync.sv
// ---------------------------------------------------------------------------
// io_sync
// N-stage flop synchronizer for a single asynchronous level.
// Ports:
//   clk_i   in  destination clock
//   rst_ni  in  asynchronous active-low reset (all stages clear to 0)
//   d_i     in  asynchronous input level
//   q_o     out synchronized level, STAGES clocks behind d_i
// ---------------------------------------------------------------------------
module io_sync #(
   parameter int STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule : io_sync

// File: rtl/io_bus_initiator.sv
// ---------------------------------------------------------------------------
// io_bus_initiator
// CPU-side initiator of the internal I/O bus. Accepts decoded I/O cycles,
// raises a request towards the far-end master, follows its IOACT handshake
// and terminates the CPU cycle (immediately for posted writes). Also drives
// the CPU->I/O address/data latch enables and the I/O->CPU read capture.
// Ports:
//   clk_i               in  CPU-side clock
//   rst_ni              in  asynchronous active-low reset
//   bact_i              in  CPU I/O cycle active, held until brdy_o
//   biowe_i             in  cycle is a write
//   biolds_i, biouds_i  in  byte lanes
//   brdy_o              out one-cycle pulse: CPU cycle may terminate
//   berr_o              out one-cycle pulse with brdy_o: bus error
//   pwerr_o             out sticky: a posted write ended in error
//   ioreq_o             out request to far end
//   iolds_o, iouds_o,
//   iowe_o              out request qualifiers, held until the next accept
//   ioact_i             in  far-end access active (asynchronous)
//   ioberr_i            in  far-end error (asynchronous), valid at ioact fall
//   ale1_o              out address latch enable (1 = transparent)
//   dle1_o              out write-data latch enable (1 = transparent)
//   rdle_o              out read-data latch capture pulse
// ---------------------------------------------------------------------------
module io_bus_initiator
   import io_bus_pkg::*;
#(
   parameter int SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int POSTWR      = 1
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic bact_i,
   input  logic biowe_i,
   input  logic biolds_i,
   input  logic biouds_i,
   output logic brdy_o,
   output logic berr_o,
   output logic pwerr_o,
   output logic ioreq_o,
   output logic iolds_o,
   output logic iouds_o,
   output logic iowe_o,
   input  logic ioact_i,
   input  logic ioberr_i,
   output logic ale1_o,
   output logic dle1_o,
   output logic rdle_o
);

   io_state_e state_q, state_d;

   logic ioact_s, ioberr_s;

   logic      armed_q, armed_d;
   logic      posted_q, posted_d;
   logic      iowe_q, iowe_d;
   io_lanes_t lanes_q, lanes_d;
   logic      ale1_q, ale1_d;
   logic      dle1_q, dle1_d;
   logic      post_brdy_q, post_brdy_d;
   logic      berr_cap_q, berr_cap_d;
   logic      pwerr_q, pwerr_d;

   // Fills with ones after reset release. Until it is full the synchronizer
   // still holds its reset zeros, so ioact_s=0 does not yet prove the far
   // end is idle (it may be finishing an access orphaned by the reset).
   logic [SYNC_STAGES-1:0] settle_q;

   logic accept;
   logic act_end;
   logic done_brdy;

   io_sync #(.STAGES(SYNC_STAGES)) u_sync_ioact (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .d_i    (ioact_i),
      .q_o    (ioact_s)
   );

   io_sync #(.STAGES(SYNC_STAGES)) u_sync_ioberr (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .d_i    (ioberr_i),
      .q_o    (ioberr_s)
   );

   assign accept  = bact_i && armed_q && (state_q == ST_IDLE) && !ioact_s
                    && settle_q[SYNC_STAGES-1];
   assign act_end = (state_q == ST_ACT) && !ioact_s;

   // A non-posted cycle is answered only if the CPU is still in the same
   // cycle: armed_q set again means BACT was seen low, i.e. the CPU aborted.
   assign done_brdy = (state_q == ST_DONE) && !posted_q && bact_i && !armed_q;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept)  state_d = ST_REQ;
         ST_REQ:  if (ioact_s) state_d = ST_ACT;
         ST_ACT:  if (!ioact_s) state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      ioreq_o = (state_q == ST_REQ);
      rdle_o  = act_end && !iowe_q;
      brdy_o  = post_brdy_q || done_brdy;
      berr_o  = done_brdy && berr_cap_q;
   end

   // ---------------- Datapath next state ----------------
   always_comb begin
      armed_d     = armed_q;
      posted_d    = posted_q;
      iowe_d      = iowe_q;
      lanes_d     = lanes_q;
      ale1_d      = ale1_q;
      dle1_d      = dle1_q;
      post_brdy_d = 1'b0;
      berr_cap_d  = berr_cap_q;
      pwerr_d     = pwerr_q;

      if (!bact_i) begin
         armed_d = 1'b1;
      end

      if (accept) begin
         armed_d     = 1'b0;
         posted_d    = (POSTWR != 0) && biowe_i;
         iowe_d      = biowe_i;
         lanes_d.lds = biolds_i;
         lanes_d.uds = biouds_i;
         ale1_d      = 1'b0;
         if (biowe_i) begin
            dle1_d = 1'b0;
         end
         // Posted write is acknowledged on the same edge that starts it.
         post_brdy_d = (POSTWR != 0) && biowe_i;
      end

      if (act_end) begin
         berr_cap_d = ioberr_s;
      end

      if (state_q == ST_DONE) begin
         ale1_d = 1'b1;
         dle1_d = 1'b1;
         if (posted_q && berr_cap_q) begin
            pwerr_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         armed_q     <= 1'b1;
         posted_q    <= 1'b0;
         iowe_q      <= 1'b0;
         lanes_q     <= '0;
         ale1_q      <= 1'b1;
         dle1_q      <= 1'b1;
         post_brdy_q <= 1'b0;
         berr_cap_q  <= 1'b0;
         pwerr_q     <= 1'b0;
         settle_q    <= '0;
      end else begin
         armed_q     <= armed_d;
         posted_q    <= posted_d;
         iowe_q      <= iowe_d;
         lanes_q     <= lanes_d;
         ale1_q      <= ale1_d;
         dle1_q      <= dle1_d;
         post_brdy_q <= post_brdy_d;
         berr_cap_q  <= berr_cap_d;
         pwerr_q     <= pwerr_d;
         settle_q    <= {settle_q[SYNC_STAGES-2:0], 1'b1};
      end
   end

   assign iowe_o  = iowe_q;
   assign iolds_o = lanes_q.lds;
   assign iouds_o = lanes_q.uds;
   assign ale1_o  = ale1_q;
   assign dle1_o  = dle1_q;
   assign pwerr_o = pwerr_q;

endmodule : io_bus_initiator

// File: tb/tb_io_bus_initiator.sv
module tb_io_bus_initiator;

   logic clk = 1'b0;
   logic rst_n;
   logic bact, biowe, biolds, biouds;
   logic ioact, ioberr;
   logic brdy, berr, pwerr, ioreq, iolds, iouds, iowe, ale1, dle1, rdle;

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   io_bus_initiator #(.SYNC_STAGES(2), .POSTWR(1)) dut (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .bact_i   (bact),
      .biowe_i  (biowe),
      .biolds_i (biolds),
      .biouds_i (biouds),
      .brdy_o   (brdy),
      .berr_o   (berr),
      .pwerr_o  (pwerr),
      .ioreq_o  (ioreq),
      .iolds_o  (iolds),
      .iouds_o  (iouds),
      .iowe_o   (iowe),
      .ioact_i  (ioact),
      .ioberr_i (ioberr),
      .ale1_o   (ale1),
      .dle1_o   (dle1),
      .rdle_o   (rdle)
   );

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic obs, input logic exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
   endtask

   // Bounded wait for the read-data capture pulse.
   task automatic wait_rdle(input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 64; i++) begin
         if (rdle === 1'b1) begin
            seen = 1'b1;
            break;
         end
         tick();
      end
      chk(tag, seen, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; bact = 1'b0; biowe = 1'b0; biolds = 1'b0; biouds = 1'b0;
      ioact = 1'b0; ioberr = 1'b0;
      tick(); tick();

      // ---- reset values ----
      chk("rst_ioreq", ioreq, 1'b0);
      chk("rst_brdy",  brdy,  1'b0);
      chk("rst_berr",  berr,  1'b0);
      chk("rst_pwerr", pwerr, 1'b0);
      chk("rst_rdle",  rdle,  1'b0);
      chk("rst_ale1",  ale1,  1'b1);
      chk("rst_dle1",  dle1,  1'b1);
      chk("rst_iowe",  iowe,  1'b0);
      chk("rst_iolds", iolds, 1'b0);
      chk("rst_iouds", iouds, 1'b0);
      rst_n = 1'b1;
      tick(); tick(); tick();

      // ---- T1: read, IOACT 6 CLK after IOREQ, held 20 CLK ----
      $display("txn: read lds=1 uds=0, far end ok");
      bact = 1'b1; biowe = 1'b0; biolds = 1'b1; biouds = 1'b0;
      chk("t1_ioreq_before", ioreq, 1'b0);
      tick();
      chk("t1_ioreq_up", ioreq, 1'b1);
      chk("t1_ale1_closed", ale1, 1'b0);
      chk("t1_dle1_open", dle1, 1'b1);
      chk("t1_iowe", iowe, 1'b0);
      chk("t1_iolds", iolds, 1'b1);
      chk("t1_iouds", iouds, 1'b0);
      chk("t1_brdy_early", brdy, 1'b0);
      repeat (5) tick();
      ioact = 1'b1;
      tick(); chk("t1_ioreq_s1", ioreq, 1'b1);
      tick(); chk("t1_ioreq_s2", ioreq, 1'b1);
      tick(); chk("t1_ioreq_drop", ioreq, 1'b0);
      repeat (17) tick();
      chk("t1_rdle_wait", rdle, 1'b0);
      ioact = 1'b0;
      tick(); chk("t1_rdle_f1", rdle, 1'b0);
      tick(); chk("t1_rdle_f2", rdle, 1'b1);
      chk("t1_brdy_f2", brdy, 1'b0);
      tick();
      chk("t1_brdy", brdy, 1'b1);
      chk("t1_berr", berr, 1'b0);
      chk("t1_rdle_gone", rdle, 1'b0);
      bact = 1'b0;
      tick();
      chk("t1_brdy_pulse", brdy, 1'b0);
      chk("t1_ale1_rel", ale1, 1'b1);

      // ---- T2: read ending in far-end error ----
      $display("txn: read, far end error");
      bact = 1'b1; biowe = 1'b0; biolds = 1'b1; biouds = 1'b1;
      tick();
      chk("t2_ioreq", ioreq, 1'b1);
      tick(); tick();
      ioact = 1'b1; ioberr = 1'b1;
      repeat (6) tick();
      ioact = 1'b0;
      wait_rdle("t2_rdle_seen");
      tick();
      chk("t2_brdy", brdy, 1'b1);
      chk("t2_berr", berr, 1'b1);
      bact = 1'b0; ioberr = 1'b0;
      tick();
      chk("t2_berr_pulse", berr, 1'b0);

      // ---- T3: posted write, then a read that waits for it ----
      $display("txn: posted write lds=1 uds=1, then read");
      bact = 1'b1; biowe = 1'b1; biolds = 1'b1; biouds = 1'b1;
      tick();
      chk("t3_brdy_post", brdy, 1'b1);
      chk("t3_berr_post", berr, 1'b0);
      chk("t3_dle1_closed", dle1, 1'b0);
      chk("t3_ale1_closed", ale1, 1'b0);
      chk("t3_iowe", iowe, 1'b1);
      chk("t3_ioreq", ioreq, 1'b1);
      bact = 1'b0;
      tick();
      chk("t3_brdy_pulse", brdy, 1'b0);
      bact = 1'b1; biowe = 1'b0; biolds = 1'b0; biouds = 1'b1;
      ioact = 1'b1;
      tick(); tick();
      chk("t3_iowe_held", iowe, 1'b1);
      tick();
      chk("t3_ioreq_drop", ioreq, 1'b0);
      ioact = 1'b0;
      tick(); tick();
      chk("t3_no_rdle_wr", rdle, 1'b0);
      tick();
      chk("t3_done_no_brdy", brdy, 1'b0);
      chk("t3_dle1_until_done", dle1, 1'b0);
      tick();
      chk("t3_dle1_rel", dle1, 1'b1);
      chk("t3_not_yet_acc", ioreq, 1'b0);
      tick();
      chk("t3_rd_accept", ioreq, 1'b1);
      chk("t3_rd_iowe", iowe, 1'b0);
      chk("t3_rd_iolds", iolds, 1'b0);
      chk("t3_rd_iouds", iouds, 1'b1);
      ioact = 1'b1;
      repeat (3) tick();
      ioact = 1'b0;
      wait_rdle("t3_rdle_seen");
      tick();
      chk("t3_rd_brdy", brdy, 1'b1);
      chk("t3_rd_berr", berr, 1'b0);
      chk("t3_pwerr", pwerr, 1'b0);
      bact = 1'b0;
      tick();

      // ---- T4: posted write with far-end error ----
      $display("txn: posted write, far end error");
      bact = 1'b1; biowe = 1'b1; biolds = 1'b0; biouds = 1'b1;
      tick();
      chk("t4_brdy_post", brdy, 1'b1);
      chk("t4_berr_post", berr, 1'b0);
      bact = 1'b0;
      ioact = 1'b1; ioberr = 1'b1;
      repeat (3) tick();
      ioact = 1'b0;
      tick(); tick(); tick();
      chk("t4_done_brdy", brdy, 1'b0);
      chk("t4_done_berr", berr, 1'b0);
      tick();
      chk("t4_pwerr_set", pwerr, 1'b1);
      ioberr = 1'b0;
      tick();

      // ---- T5: CPU aborts during ACT ----
      $display("txn: read aborted by CPU");
      bact = 1'b1; biowe = 1'b0; biolds = 1'b1; biouds = 1'b0;
      tick();
      chk("t5_ioreq", ioreq, 1'b1);
      ioact = 1'b1;
      repeat (3) tick();
      bact = 1'b0; ioact = 1'b0;
      tick(); tick();
      chk("t5_rdle", rdle, 1'b1);
      tick();
      chk("t5_no_brdy", brdy, 1'b0);
      chk("t5_ale1_in_done", ale1, 1'b0);
      tick();
      chk("t5_ale1_rel", ale1, 1'b1);
      chk("t5_dle1_rel", dle1, 1'b1);
      chk("t5_pwerr_sticky", pwerr, 1'b1);

      // ---- T6: next cycle accepted, then reset while in ACT ----
      $display("txn: read interrupted by reset");
      bact = 1'b1; biowe = 1'b1; biolds = 1'b1; biouds = 1'b1;
      biowe = 1'b0;
      tick();
      chk("t6_accept", ioreq, 1'b1);
      chk("t6_ale1", ale1, 1'b0);
      ioact = 1'b1;
      repeat (3) tick();
      rst_n = 1'b0;
      #1;
      chk("t6_rst_ale1", ale1, 1'b1);
      chk("t6_rst_iolds", iolds, 1'b0);
      chk("t6_rst_pwerr", pwerr, 1'b0);
      chk("t6_rst_ioreq", ioreq, 1'b0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t6_stall_act", ioreq, 1'b0);
      end
      ioact = 1'b0;
      tick(); chk("t6_stall_f1", ioreq, 1'b0);
      tick(); chk("t6_stall_f2", ioreq, 1'b0);
      tick(); chk("t6_accept_after", ioreq, 1'b1);
      ioact = 1'b1;
      repeat (3) tick();
      ioact = 1'b0;
      wait_rdle("t6_rdle_seen");
      tick();
      chk("t6_brdy", brdy, 1'b1);
      bact = 1'b0;
      tick();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule : tb_io_bus_initiator
